systolic_matmul_array: RTL and testbench
========================================

# systolic_matmul_array

Parametrised output-stationary systolic array. It computes C = A·B for an N×K matrix A and a K×N matrix B, with K chosen per job at run time. Operands stream in one k-slice per beat, with internal input skewing and valid/ready flow control, and results drain out one row per handshake. This block succeeds the fixed 2×2, 4-bit matrix multiplier as the reusable matrix engine of the design.

## Interface
Parameters:
- N, default 2: array dimension; the block has N×N PEs.
- DW, default 4: operand width.
- KMAX, default 8: maximum inner dimension.
- Derived localparams:
  - AW = 2*DW + $clog2(KMAX): accumulator and result width.
  - KW = $clog2(KMAX+1).

Ports:
- clk, in, 1: single clock; all logic on the rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: job request; sampled only in IDLE.
- k_len, in, KW: inner dimension K, sampled with start; legal range 0..KMAX.
- busy, out, 1: high from start acceptance until done.
- a_col, in, N*DW: A[i][k] at bits [i*DW +: DW].
- b_row, in, N*DW: B[k][j] at bits [j*DW +: DW].
- in_valid, in, 1: a_col and b_row hold one k-slice.
- in_ready, out, 1: high only in LOAD.
- out_row, out, N*AW: C[out_idx][j] at bits [j*AW +: AW].
- out_idx, out, $clog2(N) (minimum 1): row index of out_row.
- out_valid, out, 1: out_row is valid.
- out_ready, in, 1: consumer accepts the row.
- done, out, 1: one-cycle pulse after the last row is accepted.

## Operation
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE:
  - start=1 clears all accumulators, latches k_len, and raises busy.
  - The FSM then goes to LOAD, or straight to FLUSH if k_len=0.
- LOAD:
  - Each in_valid&in_ready beat consumes one k-slice.
  - After the K-th beat the FSM goes to FLUSH.
  - Beats are taken in order k = 0..K-1.
- Skewing:
  - Row i of A is delayed i cycles; column j of B is delayed j cycles.
  - A operands shift right and B operands shift down one PE per cycle.
  - Each PE executes acc += a*b every cycle.
- Bubbles: in any cycle without an accepted beat (LOAD bubble or FLUSH), zero operands are injected. The array free-runs and bubbles never corrupt results.
- FLUSH: exactly 2N-1 cycles of zero injection, then DRAIN.
- DRAIN:
  - Presents rows idx = 0..N-1, advancing on out_valid&out_ready.
  - out_row and out_idx are held stable while out_valid=1 and out_ready=0.
  - After the row N-1 handshake: done=1 for one cycle, busy=0, FSM returns to IDLE.
- Arithmetic: operands are unsigned by default and products are extended to AW. The sum never overflows for K ≤ KMAX.
- k_len > KMAX is clamped to KMAX. k_len=0 yields all-zero rows.
- start outside IDLE is ignored. in_valid outside LOAD is ignored.
- rst_n asserted mid-job aborts it; the next job after release is unaffected.

## Timing
- Reset values: state=IDLE, busy=0, in_ready=0, out_valid=0, out_row=0, out_idx=0, done=0, all accumulators and skew/PE registers 0.
- start is accepted at edge t; in_ready=1 from cycle t+1.
- The last beat is accepted at edge u; in_ready=0 from cycle u+1.
- First out_valid=1 in cycle u+2N (FLUSH occupies cycles u+1..u+2N-1).
- One row per cycle with out_ready held high; minimum DRAIN time N cycles.
- done is high in the first IDLE cycle after DRAIN. start is accepted in that same cycle.
- Total latency with no stalls: 1 + K + (2N-1) + N cycles from start to done.

## Configuration
- SYSTOLIC_SIGNED_EN:
  - Defined: operands are two's complement, products and accumulators are signed, and results are sign-extended to AW.
  - Undefined: everything is unsigned and zero-extended.
- Latency, handshakes and widths are identical in both builds.

## Test plan
All scenarios use N=2, DW=4, KMAX=8, so AW=11.
- Basic 2×2: K=2, beat0 a_col=(1,3), b_row=(5,6); beat1 a_col=(2,4), b_row=(7,8) → row0=(19,22), row1=(43,50). First out_valid 4 cycles after the last beat; done after row1.
- Max unsigned: K=8, all operands 15 → every element 1800 (0x708); no wrap.
- Bubbles and zero K: repeat the basic job with in_valid low for 3 cycles between beats → identical results. A k_len=0 job → both rows all zero.
- Backpressure: out_ready low for 5 cycles during row0 → out_valid stays 1 and out_row/out_idx are stable. Row1 follows after out_ready rises; done pulses once.
- Reset mid-LOAD: rst_n low after beat0 → busy, in_ready, out_valid and out_row go to 0 immediately. A fresh basic job after release gives the correct results. A start asserted mid-job is ignored.
- SYSTOLIC_SIGNED_EN defined: K=2, all A=-8 (0x8), all B=7 → every element -112 (0x790).

Source files
------------

// File: rtl/systolic_matmul_array.sv
// Output-stationary N x N systolic matrix multiplier with run-time inner dimension K.
// Build option: define SYSTOLIC_SIGNED_EN for two's-complement operands and results.
module systolic_matmul_array #(
    parameter  int N    = 2,
    parameter  int DW   = 4,
    parameter  int KMAX = 8,
    localparam int AW   = 2*DW + $clog2(KMAX),
    localparam int KW   = $clog2(KMAX+1),
    localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    output logic            busy,
    input  logic [N*DW-1:0] a_col,
    input  logic [N*DW-1:0] b_row,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [N*AW-1:0] out_row,
    output logic [IW-1:0]   out_idx,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;
    localparam int FW = $clog2(2*N);

    logic [1:0]    state;
    logic [KW-1:0] k_lat;
    logic [KW-1:0] beat_cnt;
    logic [FW-1:0] flush_cnt;
    logic [IW-1:0] row_idx;
    logic [KW-1:0] k_clamp;
    logic          beat;
    logic          clr;

    logic [DW-1:0] a_h   [N][N];
    logic [DW-1:0] b_v   [N][N];
    logic [AW-1:0] acc_h [N][N];

    function automatic logic [AW-1:0] prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef SYSTOLIC_SIGNED_EN
        logic signed [2*DW-1:0] sa;
        logic signed [2*DW-1:0] sb;
        logic signed [2*DW-1:0] p;
        sa = {{DW{a[DW-1]}}, a};
        sb = {{DW{b[DW-1]}}, b};
        p  = sa * sb;
        return AW'(p);
`else
        logic [2*DW-1:0] p;
        p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        return AW'(p);
`endif
    endfunction

    assign beat      = in_valid && (state == S_LOAD);
    assign clr       = start && (state == S_IDLE);
    assign k_clamp   = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;
    assign busy      = (state != S_IDLE);
    assign in_ready  = (state == S_LOAD);
    assign out_valid = (state == S_DRAIN);
    assign out_idx   = row_idx;

    // Input skew: row i of A and column j of B are each delayed by their index;
    // cycles without an accepted beat inject zeros so the array can free-run.
    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [DW-1:0] a_inj;
        logic [DW-1:0] b_inj;
        assign a_inj = beat ? a_col[i*DW +: DW] : '0;
        assign b_inj = beat ? b_row[i*DW +: DW] : '0;
        if (i == 0) begin : g_direct
            assign a_h[0][0] = a_inj;
            assign b_v[0][0] = b_inj;
        end else begin : g_dly
            logic [DW-1:0] a_sr_p0 [i];
            logic [DW-1:0] b_sr_p0 [i];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < i; s++) begin
                        a_sr_p0[s] <= '0;
                        b_sr_p0[s] <= '0;
                    end
                end else begin
                    a_sr_p0[0] <= a_inj;
                    b_sr_p0[0] <= b_inj;
                    for (int s = 1; s < i; s++) begin
                        a_sr_p0[s] <= a_sr_p0[s-1];
                        b_sr_p0[s] <= b_sr_p0[s-1];
                    end
                end
            end
            assign a_h[i][0] = a_sr_p0[i-1];
            assign b_v[0][i] = b_sr_p0[i-1];
        end
    end

    // PE grid: A moves right, B moves down, each PE accumulates in place.
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_pe
            logic [AW-1:0] acc_p1;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    acc_p1 <= '0;
                else if (clr)
                    acc_p1 <= '0;
                else
                    acc_p1 <= acc_p1 + prod(a_h[i][j], b_v[i][j]);
            end
            assign acc_h[i][j] = acc_p1;

            if (j < N-1) begin : g_afwd
                logic [DW-1:0] a_p1;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)
                        a_p1 <= '0;
                    else if (clr)
                        a_p1 <= '0;
                    else
                        a_p1 <= a_h[i][j];
                end
                assign a_h[i][j+1] = a_p1;
            end

            if (i < N-1) begin : g_bfwd
                logic [DW-1:0] b_p1;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)
                        b_p1 <= '0;
                    else if (clr)
                        b_p1 <= '0;
                    else
                        b_p1 <= b_v[i][j];
                end
                assign b_v[i+1][j] = b_p1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            k_lat     <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row_idx   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_lat     <= k_clamp;
                        beat_cnt  <= '0;
                        flush_cnt <= '0;
                        state     <= (k_clamp == '0) ? S_FLUSH : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        beat_cnt <= beat_cnt + KW'(1);
                        if (beat_cnt == k_lat - KW'(1)) begin
                            flush_cnt <= '0;
                            state     <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    // Last PE sees its final operand pair 2N-2 cycles after the last beat.
                    if (flush_cnt == FW'(2*N-2)) begin
                        row_idx <= '0;
                        state   <= S_DRAIN;
                    end else begin
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end
                default: begin
                    if (out_ready) begin
                        if (row_idx == IW'(N-1)) begin
                            row_idx <= '0;
                            done    <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            row_idx <= row_idx + IW'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        out_row = '0;
        if (state == S_DRAIN) begin
            for (int j = 0; j < N; j++)
                out_row[j*AW +: AW] = acc_h[row_idx][j];
        end
    end

endmodule

// File: tb/tb_systolic_matmul_array.sv
// Scoreboard bench for systolic_matmul_array at N=2, DW=4, KMAX=8 (AW=11).
module tb_systolic_matmul_array;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  k_len;
    logic        busy;
    logic [7:0]  a_col;
    logic [7:0]  b_row;
    logic        in_valid;
    logic        in_ready;
    logic [21:0] out_row;
    logic [0:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic        done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [21:0] exp_row_q [$];
    int          exp_idx_q [$];
    logic [7:0]  av [8];
    logic [7:0]  bv [8];

    systolic_matmul_array #(.N(2), .DW(4), .KMAX(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy),
        .a_col(a_col), .b_row(b_row), .in_valid(in_valid), .in_ready(in_ready),
        .out_row(out_row), .out_idx(out_idx), .out_valid(out_valid),
        .out_ready(out_ready), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expected row on every output handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_row_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_row: got idx %0d row 0x%0h required no output", out_idx, out_row);
            end else begin
                logic [21:0] r;
                int          ix;
                r  = exp_row_q.pop_front();
                ix = exp_idx_q.pop_front();
                check("row_idx", 32'(out_idx), 32'(ix));
                check("row_data", 32'(out_row), 32'(r));
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] a, input logic [7:0] b);
        bit ok;
        int n;
        n = 0;
        a_col = a;
        b_row = b;
        in_valid = 1'b1;
        do begin
            ok = in_ready;
            tick();
            n++;
        end while (!ok && n < 50);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout: got in_ready 0 required 1");
        end
        in_valid = 1'b0;
        a_col = '0;
        b_row = '0;
    endtask

    task automatic run_job(input string tag, input logic [3:0] k, input int nb,
                           input int gap, input logic [21:0] r0, input logic [21:0] r1,
                           input bit lat_chk, input bit bp, input bit mid_start);
        int d0;
        int n;
        d0 = done_cnt;
        exp_row_q.push_back(r0); exp_idx_q.push_back(0);
        exp_row_q.push_back(r1); exp_idx_q.push_back(1);
        out_ready = !bp;
        start = 1'b1;
        k_len = k;
        tick();
        start = 1'b0;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        check({tag, "_in_ready_start"}, 32'(in_ready), (nb != 0) ? 32'd1 : 32'd0);
        for (int b = 0; b < nb; b++) begin
            if (b > 0) repeat (gap) tick();
            send_beat(av[b], bv[b]);
            if (mid_start && b == 0) begin
                start = 1'b1;
                k_len = 4'd0;
                tick();
                start = 1'b0;
                check({tag, "_mid_start_ignored"}, 32'(in_ready), 32'd1);
            end
        end
        if (lat_chk) begin
            n = 0;
            while (!out_valid && n < 20) begin tick(); n++; end
            check({tag, "_first_valid_latency"}, 32'(n), 32'd3);
        end
        if (bp) begin
            n = 0;
            while (!out_valid && n < 50) begin tick(); n++; end
            for (int c = 0; c < 5; c++) begin
                check({tag, "_bp_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_bp_idx"}, 32'(out_idx), 32'd0);
                check({tag, "_bp_row"}, 32'(out_row), 32'(r0));
                tick();
            end
            out_ready = 1'b1;
        end
        n = 0;
        while (done_cnt == d0 && n < 100) begin tick(); n++; end
        repeat (2) tick();
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic set_basic();
        av[0] = 8'h31; bv[0] = 8'h65;
        av[1] = 8'h42; bv[1] = 8'h87;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst_n = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0;
        a_col = '0; b_row = '0; out_ready = 1'b1;
        repeat (2) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_row", 32'(out_row), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();

`ifdef SYSTOLIC_SIGNED_EN
        av[0] = 8'h88; bv[0] = 8'h77;
        av[1] = 8'h88; bv[1] = 8'h77;
        run_job("signed", 4'd2, 2, 0, {11'h790, 11'h790}, {11'h790, 11'h790}, 1'b1, 1'b0, 1'b0);
        run_job("zero_k", 4'd0, 0, 0, 22'd0, 22'd0, 1'b0, 1'b0, 1'b0);
`else
        set_basic();
        run_job("basic", 4'd2, 2, 0, {11'd22, 11'd19}, {11'd50, 11'd43}, 1'b1, 1'b0, 1'b0);

        for (int b = 0; b < 8; b++) begin av[b] = 8'hFF; bv[b] = 8'hFF; end
        run_job("max", 4'd8, 8, 0, {11'd1800, 11'd1800}, {11'd1800, 11'd1800}, 1'b1, 1'b0, 1'b0);

        for (int b = 0; b < 8; b++) begin av[b] = 8'h11; bv[b] = 8'h11; end
        run_job("clamp", 4'd15, 8, 0, {11'd8, 11'd8}, {11'd8, 11'd8}, 1'b1, 1'b0, 1'b0);

        // Junk on in_valid while idle must not reach the array.
        in_valid = 1'b1; a_col = 8'hFF; b_row = 8'hFF;
        repeat (2) tick();
        in_valid = 1'b0; a_col = '0; b_row = '0;
        set_basic();
        run_job("bubbles", 4'd2, 2, 3, {11'd22, 11'd19}, {11'd50, 11'd43}, 1'b0, 1'b0, 1'b1);

        run_job("zero_k", 4'd0, 0, 0, 22'd0, 22'd0, 1'b0, 1'b0, 1'b0);

        run_job("backpressure", 4'd2, 2, 0, {11'd22, 11'd19}, {11'd50, 11'd43}, 1'b0, 1'b1, 1'b0);

        d0 = done_cnt;
        start = 1'b1; k_len = 4'd2;
        tick();
        start = 1'b0;
        send_beat(8'h31, 8'h65);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_row", 32'(out_row), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_job("after_reset", 4'd2, 2, 0, {11'd22, 11'd19}, {11'd50, 11'd43}, 1'b1, 1'b0, 1'b0);
`endif

        repeat (3) tick();
        check("scoreboard_empty", 32'(exp_row_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
